// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// default frame geometry, counter widths and the parity helper.
package uart_pkg;

    // Default frame geometry; instances may override through parameters.
    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;

    // Counter widths for the default geometry.
    localparam int TICK_W = $clog2(OVERSAMPLE_DEF);
    localparam int BIT_W  = $clog2(DATA_BITS_DEF);

    // Serializer states. Values are fixed so the debug state bus is stable.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Width of a counter that must hold values 0..n-1 (never below 1 bit).
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Parity over up to 9 data bits. Unused upper bits must be zero.
    // odd=0 gives even parity (total ones incl. parity bit is even).
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pulls one byte from a show-ahead TX FIFO and
// shifts it out as start / data (LSB first) / optional parity / stop bits.
// Each bit lasts exactly OVERSAMPLE baud_tick pulses.
//
// FIFO handshake: fifo_empty=0 acts as "valid" for fifo_data; fifo_pop acts
// as "ready" and is a combinational single-cycle pulse. A transfer happens on
// the clk edge where fifo_pop=1; data is latched on that same edge. fifo_pop
// only rises in IDLE with fifo_empty=0, bist_mode=0 and rst=0, so it can
// never pop an empty FIFO and pops at most once per frame.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 bist_mode,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_pop,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 frame_done,
    output logic [2:0]           state_dbg
);

    // Counter widths follow this instance's parameters.
    localparam int TW = cnt_w(OVERSAMPLE);
    localparam int BW = cnt_w(DATA_BITS);

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS > 1);
    localparam logic          ODD_SEL   = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_PARITY = ST_PARITY;
    localparam logic [2:0] S_STOP   = ST_STOP;

    logic [2:0]           state_q,    state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 parity_q,   parity_d;
    logic                 tx_q,       tx_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;

    logic start_ok;
    logic bit_end;

    // Frame start is allowed only from IDLE; rst suppresses the pop so a
    // held FIFO entry is not consumed while the block is in reset.
    assign start_ok = (state_q == S_IDLE) && !fifo_empty && !bist_mode && !rst;

    // The current bit finishes on the tick that completes its OVERSAMPLE count.
    assign bit_end  = baud_tick && (tick_cnt_q == TICK_LAST);

    // Next-state logic: tx_d always carries the level for the coming bit so
    // the line output is a plain register.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // Tick counting only runs inside a frame; IDLE holds it at zero.
        if (state_q != S_IDLE && baud_tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                if (start_ok) begin
                    shift_d    = fifo_data;
                    parity_d   = (PARITY_EN != 0) ? calc_parity(9'(fifo_data), ODD_SEL) : 1'b0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = S_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        stop_cnt_d = 1'b0;
                        state_d    = S_IDLE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d    = S_IDLE;
                tick_cnt_d = '0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any frame on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fifo_pop   = start_ok;
    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign frame_done = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer. Three instances cover the default frame,
// odd parity with two stop bits, and a 5-bit / no-parity / x8 frame. The
// reference model expands each popped byte into its list of line levels and
// looks up the expected tx level from the number of ticks seen since the pop.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    // Clock / stimulus signals
    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       bist_mode;
    logic [2:0] fifo_empty;
    logic [7:0] fifo_data;

    logic [2:0] pop_w, tx_w, busy_w, done_w;
    logic [2:0] st_w [3];

    // Frame geometry of each instance
    int cfg_db [3] = '{8, 8, 5};
    int cfg_pe [3] = '{1, 1, 0};
    int cfg_po [3] = '{0, 1, 0};
    int cfg_sb [3] = '{1, 2, 1};
    int cfg_os [3] = '{16, 16, 8};

    uart_tx_serializer u_a (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bist_mode(bist_mode),
        .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[7:0]),
        .fifo_pop(pop_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]),
        .frame_done(done_w[0]), .state_dbg(st_w[0])
    );

    uart_tx_serializer #(.PARITY_ODD(1), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bist_mode(bist_mode),
        .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[7:0]),
        .fifo_pop(pop_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]),
        .frame_done(done_w[1]), .state_dbg(st_w[1])
    );

    uart_tx_serializer #(.DATA_BITS(5), .PARITY_EN(0), .OVERSAMPLE(8)) u_c (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bist_mode(bist_mode),
        .fifo_empty(fifo_empty[2]), .fifo_data(fifo_data[4:0]),
        .fifo_pop(pop_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]),
        .frame_done(done_w[2]), .state_dbg(st_w[2])
    );

    // Clock
    always #5 clk = ~clk;

    // Bench state: FIFO contents (expected data queue) and reference model
    logic [7:0] exp_q [$];
    logic       m_bits [$];
    int         m_in_frame, m_ticks;
    logic       exp_tx, exp_busy, exp_done;
    int         sel, tick_per, tick_ct;
    logic       rst_r, bist_r;
    int         n_tests, n_fail, n_pops, n_done;
    int         p0, d0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cfg=%0d t=%0t got=%0h exp=%0h", tag, sel, $time, obs, exp);
        end
    endtask

    // Line levels of one frame for the selected configuration.
    task automatic build_frame(input logic [7:0] d);
        logic par;
        m_bits.delete();
        m_bits.push_back(1'b0);
        par = cfg_po[sel][0];
        for (int i = 0; i < cfg_db[sel]; i++) begin
            m_bits.push_back(d[i]);
            par = par ^ d[i];
        end
        if (cfg_pe[sel] != 0) m_bits.push_back(par);
        for (int s = 0; s < cfg_sb[sel]; s++) m_bits.push_back(1'b1);
    endtask

    // One clock: check registered outputs, drive inputs, check pop, advance model.
    task automatic step();
        logic exp_pop;
        int   os;
        @(negedge clk);
        os = cfg_os[sel];
        chk("tx", 32'(tx_w[sel]), 32'(exp_tx));
        chk("tx_busy", 32'(busy_w[sel]), 32'(exp_busy));
        chk("frame_done", 32'(done_w[sel]), 32'(exp_done));
        if (m_in_frame == 0) chk("state_idle", 32'(st_w[sel]), 32'(ST_IDLE));
        if (done_w[sel]) n_done++;

        tick_ct++;
        if (tick_ct >= tick_per) begin
            baud_tick = 1'b1;
            tick_ct   = 0;
        end else begin
            baud_tick = 1'b0;
        end
        rst        = rst_r;
        bist_mode  = bist_r;
        fifo_empty = 3'b111;
        if (exp_q.size() != 0) begin
            fifo_empty[sel] = 1'b0;
            fifo_data       = exp_q[0];
        end else begin
            fifo_data = 8'($urandom);
        end
        #1;
        exp_pop = !rst_r && (m_in_frame == 0) && (exp_q.size() != 0) && !bist_r;
        chk("fifo_pop", 32'(pop_w[sel]), 32'(exp_pop));
        chk("other_pop", 32'(pop_w & ~(3'b001 << sel)), 32'd0);
        if (pop_w[sel]) n_pops++;

        if (rst_r) begin
            m_in_frame = 0;
            exp_tx     = 1'b1;
            exp_busy   = 1'b0;
            exp_done   = 1'b0;
        end else if (m_in_frame == 0) begin
            exp_done = 1'b0;
            if (exp_pop) begin
                build_frame(exp_q.pop_front());
                m_in_frame = 1;
                m_ticks    = 0;
                exp_tx     = m_bits[0];
                exp_busy   = 1'b1;
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
        end else begin
            if (baud_tick) m_ticks++;
            if (m_ticks == m_bits.size() * os) begin
                m_in_frame = 0;
                exp_tx     = 1'b1;
                exp_busy   = 1'b0;
                exp_done   = 1'b1;
            end else begin
                exp_tx   = m_bits[m_ticks / os];
                exp_busy = 1'b1;
                exp_done = 1'b0;
            end
        end
    endtask

    // Run until the FIFO is empty and no frame is in flight.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_in_frame != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n >= budget), 32'd0);
        repeat (3) step();
    endtask

    // Run until the model is at least min_ticks into a frame.
    task automatic wait_ticks(input int min_ticks, input int budget);
        int n;
        n = 0;
        while (!(m_in_frame != 0 && m_ticks >= min_ticks) && n < budget) begin
            step();
            n++;
        end
        chk("wait_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic wait_frame_end(input int budget);
        int n;
        n = 0;
        while (m_in_frame != 0 && n < budget) begin
            step();
            n++;
        end
        chk("frame_end_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic mark();
        p0 = n_pops;
        d0 = n_done;
    endtask

    task automatic random_frames(input int nf);
        for (int f = 0; f < nf; f++) begin
            tick_per = $urandom_range(1, 4);
            repeat ($urandom_range(1, 3)) exp_q.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                bist_r = 1'b1;
                repeat ($urandom_range(1, 200)) step();
                bist_r = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(10, 400)) step();
                rst_r = 1'b1;
                step();
                rst_r = 1'b0;
            end
            drain(4000);
        end
    endtask

    // Watchdog
    initial begin
        #3ms;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Main sequence
    initial begin
        rst        = 1'b1;
        bist_mode  = 1'b0;
        baud_tick  = 1'b0;
        fifo_empty = 3'b111;
        fifo_data  = 8'h00;
        rst_r      = 1'b1;
        bist_r     = 1'b0;
        sel        = 0;
        tick_per   = 4;
        tick_ct    = 0;
        m_in_frame = 0;
        m_ticks    = 0;
        exp_tx     = 1'b1;
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        n_tests    = 0;
        n_fail     = 0;
        n_pops     = 0;
        n_done     = 0;

        // Reset state
        repeat (3) step();
        rst_r = 1'b0;
        repeat (2) step();

        // Single 0xA5 frame, ticks every 4 clk
        mark();
        exp_q.push_back(8'hA5);
        drain(2000);
        chk("a5_pops", 32'(n_pops - p0), 32'd1);
        chk("a5_done", 32'(n_done - d0), 32'd1);

        // Back-to-back 0x55, 0x0F
        mark();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h0F);
        drain(3000);
        chk("b2b_pops", 32'(n_pops - p0), 32'd2);
        chk("b2b_done", 32'(n_done - d0), 32'd2);

        // bist_mode raised mid-frame
        mark();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        wait_ticks(40, 2000);
        bist_r = 1'b1;
        wait_frame_end(2000);
        repeat (300) step();
        chk("bist_pops", 32'(n_pops - p0), 32'd1);
        bist_r = 1'b0;
        drain(2000);
        chk("bist_pops_after", 32'(n_pops - p0), 32'd2);

        // rst during DATA bit 3
        mark();
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h69);
        wait_ticks(4 * 16 + 8, 2000);
        rst_r = 1'b1;
        repeat (3) step();
        chk("rst_pops", 32'(n_pops - p0), 32'd1);
        rst_r = 1'b0;
        drain(2000);
        chk("rst_pops_after", 32'(n_pops - p0), 32'd2);
        chk("rst_done", 32'(n_done - d0), 32'd1);

        // Empty FIFO with ticks running
        mark();
        tick_per = 2;
        repeat (1000) step();
        chk("empty_pops", 32'(n_pops - p0), 32'd0);

        random_frames(10);

        // Odd parity, two stop bits, data 0x00
        sel      = 1;
        tick_per = 1;
        mark();
        exp_q.push_back(8'h00);
        drain(1000);
        chk("odd_pops", 32'(n_pops - p0), 32'd1);
        chk("odd_done", 32'(n_done - d0), 32'd1);
        random_frames(6);

        // 5 data bits, no parity, x8 oversample
        sel = 2;
        mark();
        exp_q.push_back(8'h15);
        exp_q.push_back(8'h0A);
        drain(2000);
        chk("c_pops", 32'(n_pops - p0), 32'd2);
        random_frames(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
